// File: rtl/lighthouse_pulse_decoder_pkg.sv
// Shared types and constants for the lighthouse pulse decoder: FSM states,
// pulse classes, counter widths and sync-code bit positions.
package lighthouse_pulse_decoder_pkg;

    localparam int T_WIDTH = 20;
    localparam int W_WIDTH = 16;

    localparam int CODE_SKIP_BIT = 2;
    localparam int CODE_DATA_BIT = 1;
    localparam int CODE_AXIS_BIT = 0;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        HIGH,
        EMIT
    } state_t;

    typedef enum logic [1:0] {
        GLITCH,
        SWEEP,
        SYNC,
        REJECT
    } pulse_class_t;

endpackage

// File: rtl/lighthouse_pulse_decoder_sensor_input_sync.sv
// Two-flop synchronizer for the photodiode envelope with polarity
// normalisation and matched-latency rise/fall strobes.
module sensor_input_sync #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sensor_i,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_ff;
    logic       level_q;

    // Reset to the "light" level so a pulse already in progress at reset
    // release never looks like a fresh rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= {2{ACTIVE_HIGH}};
            level_q <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[0], sensor_i};
            level_q <= level;
        end
    end

    assign level = (sync_ff[1] == ACTIVE_HIGH);
    assign rise  = level & ~level_q;
    assign fall  = ~level & level_q;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Per-sensor lighthouse pulse decoder: measures pulses, classifies sync/sweep
// and timestamps sweeps. Optional statistics counters: DARKROOM_PULSE_STATS_EN.
module lighthouse_pulse_decoder
    import lighthouse_pulse_decoder_pkg::*;
#(
    parameter bit          ACTIVE_HIGH = 1'b1,
    parameter int unsigned MIN_PULSE   = 25,
    parameter int unsigned SWEEP_MAX   = 2000,
    parameter int unsigned SYNC_MIN    = 2865,
    parameter int unsigned SYNC_STEP   = 521,
    parameter int unsigned PAIR_WINDOW = 30000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sensor_i,
    output logic               sync_valid_o,
    output logic               sync_skip_o,
    output logic               sync_data_o,
    output logic               sync_axis_o,
    output logic               sync_station_o,
    output logic               sweep_valid_o,
    output logic               sweep_axis_o,
    output logic               sweep_station_o,
    output logic [T_WIDTH-1:0] sweep_time_o,
    output logic [W_WIDTH-1:0] sweep_width_o,
    output logic [15:0]        stat_sync_cnt_o,
    output logic [15:0]        stat_sweep_cnt_o,
    output logic [15:0]        stat_reject_cnt_o
);

    localparam logic [T_WIDTH-1:0] T_MAX = '1;
    localparam logic [W_WIDTH-1:0] W_MAX = '1;

    logic level, rise, fall;

    sensor_input_sync #(.ACTIVE_HIGH(ACTIVE_HIGH)) u_input (
        .clk      (clk),
        .reset_n  (reset_n),
        .sensor_i (sensor_i),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    state_t             state;
    logic [W_WIDTH-1:0] width;
    logic [T_WIDTH-1:0] t_ref;
    logic [T_WIDTH-1:0] rise_t;
    logic [W_WIDTH-1:0] t_pair;
    logic [W_WIDTH-1:0] pair_at_rise;
    logic               sync_seen;
    logic               ref_axis;
    logic               ref_station;

    pulse_class_t pulse_class;
    logic [2:0]   code;
    logic         station;
    logic [31:0]  w_ext;

    assign w_ext = 32'(width);

    // Sync code is the highest threshold the width reaches; a compare chain
    // stands in for the division by SYNC_STEP.
    always_comb begin
        code = '0;
        for (int k = 1; k < 8; k++) begin
            if (w_ext >= SYNC_MIN + k * SYNC_STEP) code = 3'(k);
        end
        station = (32'(pair_at_rise) < PAIR_WINDOW);
        if (w_ext < MIN_PULSE)
            pulse_class = GLITCH;
        else if (w_ext <= SWEEP_MAX)
            pulse_class = (sync_seen && rise_t != T_MAX) ? SWEEP : REJECT;
        else if (w_ext >= SYNC_MIN && w_ext < SYNC_MIN + 8 * SYNC_STEP)
            pulse_class = SYNC;
        else
            pulse_class = REJECT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_LOW;
            width           <= '0;
            t_ref           <= '0;
            rise_t          <= '0;
            t_pair          <= '0;
            pair_at_rise    <= '0;
            sync_seen       <= 1'b0;
            ref_axis        <= 1'b0;
            ref_station     <= 1'b0;
            sync_valid_o    <= 1'b0;
            sync_skip_o     <= 1'b0;
            sync_data_o     <= 1'b0;
            sync_axis_o     <= 1'b0;
            sync_station_o  <= 1'b0;
            sweep_valid_o   <= 1'b0;
            sweep_axis_o    <= 1'b0;
            sweep_station_o <= 1'b0;
            sweep_time_o    <= '0;
            sweep_width_o   <= '0;
        end else begin
            sync_valid_o  <= 1'b0;
            sweep_valid_o <= 1'b0;
            if (t_ref != T_MAX) t_ref <= t_ref + 1'b1;
            else                sync_seen <= 1'b0;
            if (t_pair != W_MAX) t_pair <= t_pair + 1'b1;

            case (state)
                WAIT_LOW: begin
                    if (!level) state <= IDLE;
                end
                IDLE, EMIT: begin
                    if (rise) begin
                        width        <= W_WIDTH'(1);
                        rise_t       <= t_ref;
                        pair_at_rise <= t_pair;
                        state        <= HIGH;
                    end else begin
                        state <= IDLE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= EMIT;
                        case (pulse_class)
                            SWEEP: begin
                                sweep_valid_o   <= 1'b1;
                                sweep_axis_o    <= ref_axis;
                                sweep_station_o <= ref_station;
                                sweep_time_o    <= rise_t;
                                sweep_width_o   <= width;
                            end
                            SYNC: begin
                                sync_valid_o   <= 1'b1;
                                sync_skip_o    <= code[CODE_SKIP_BIT];
                                sync_data_o    <= code[CODE_DATA_BIT];
                                sync_axis_o    <= code[CODE_AXIS_BIT];
                                sync_station_o <= station;
                                // Counters restart as if cleared at this pulse's rise.
                                t_pair <= width + 1'b1;
                                if (!code[CODE_SKIP_BIT]) begin
                                    t_ref       <= T_WIDTH'(width) + 1'b1;
                                    ref_axis    <= code[CODE_AXIS_BIT];
                                    ref_station <= station;
                                    sync_seen   <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (width != W_MAX) begin
                        width <= width + 1'b1;
                    end
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

`ifdef DARKROOM_PULSE_STATS_EN
    logic        classify;
    logic [15:0] sync_cnt, sweep_cnt, reject_cnt;

    assign classify = (state == HIGH) && fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_cnt   <= '0;
            sweep_cnt  <= '0;
            reject_cnt <= '0;
        end else if (classify) begin
            case (pulse_class)
                SYNC:    sync_cnt   <= sync_cnt + 1'b1;
                SWEEP:   sweep_cnt  <= sweep_cnt + 1'b1;
                default: reject_cnt <= reject_cnt + 1'b1;
            endcase
        end
    end

    assign stat_sync_cnt_o   = sync_cnt;
    assign stat_sweep_cnt_o  = sweep_cnt;
    assign stat_reject_cnt_o = reject_cnt;
`else
    assign stat_sync_cnt_o   = '0;
    assign stat_sweep_cnt_o  = '0;
    assign stat_reject_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Self-checking bench for lighthouse_pulse_decoder: directed and random pulse
// trains checked against a cycle-level behavioural model of pulse events.
`timescale 1ns/1ps
module tb_lighthouse_pulse_decoder;

    localparam int unsigned MIN_PULSE   = 25;
    localparam int unsigned SWEEP_MAX   = 2000;
    localparam int unsigned SYNC_MIN    = 2865;
    localparam int unsigned SYNC_STEP   = 521;
    localparam longint      PAIR_WINDOW = 30000;
    localparam longint      T_MAX       = 64'hFFFFF;

    logic        clk;
    logic        reset_n;
    logic        sensor_i;
    logic        sync_valid_o, sync_skip_o, sync_data_o, sync_axis_o, sync_station_o;
    logic        sweep_valid_o, sweep_axis_o, sweep_station_o;
    logic [19:0] sweep_time_o;
    logic [15:0] sweep_width_o;
    logic [15:0] stat_sync_cnt_o, stat_sweep_cnt_o, stat_reject_cnt_o;

    lighthouse_pulse_decoder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sensor_i          (sensor_i),
        .sync_valid_o      (sync_valid_o),
        .sync_skip_o       (sync_skip_o),
        .sync_data_o       (sync_data_o),
        .sync_axis_o       (sync_axis_o),
        .sync_station_o    (sync_station_o),
        .sweep_valid_o     (sweep_valid_o),
        .sweep_axis_o      (sweep_axis_o),
        .sweep_station_o   (sweep_station_o),
        .sweep_time_o      (sweep_time_o),
        .sweep_width_o     (sweep_width_o),
        .stat_sync_cnt_o   (stat_sync_cnt_o),
        .stat_sweep_cnt_o  (stat_sweep_cnt_o),
        .stat_reject_cnt_o (stat_reject_cnt_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_SYNC, EV_SWEEP, EV_REJECT} ev_kind_t;
    typedef struct {
        longint      due;
        ev_kind_t    kind;
        logic        skip, data, axis, station;
        logic [19:0] t_val;
        logic [15:0] w_val;
    } pulse_event_t;

    pulse_event_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: absolute drive-cycle timestamps of reference and last sync rises.
    bit     have_ref, have_prev, ref_axis, ref_station;
    longint ref_rise, prev_sync_rise;

    // Output values the DUT should currently be holding.
    logic        h_skip, h_data, h_axis, h_station, h_sw_axis, h_sw_station;
    logic [19:0] h_sw_time;
    logic [15:0] h_sw_width;
    logic [15:0] s_sync, s_sweep, s_reject;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic resetModel();
        have_ref = 0; have_prev = 0; ref_axis = 0; ref_station = 0;
        ref_rise = 0; prev_sync_rise = 0;
        h_skip = 0; h_data = 0; h_axis = 0; h_station = 0;
        h_sw_axis = 0; h_sw_station = 0; h_sw_time = 0; h_sw_width = 0;
        s_sync = 0; s_sweep = 0; s_reject = 0;
        exp_q.delete();
    endtask

    // One clock: sample at the falling edge, compare strobes against due events.
    task automatic tick();
        pulse_event_t ev;
        bit exp_sync, exp_sweep;
        @(negedge clk);
        exp_sync = 0;
        exp_sweep = 0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = exp_q.pop_front();
            if (ev.kind == EV_SYNC) begin
                exp_sync = 1;
                h_skip = ev.skip; h_data = ev.data; h_axis = ev.axis; h_station = ev.station;
                s_sync++;
            end else if (ev.kind == EV_SWEEP) begin
                exp_sweep = 1;
                h_sw_axis = ev.axis; h_sw_station = ev.station;
                h_sw_time = ev.t_val; h_sw_width = ev.w_val;
                s_sweep++;
            end else begin
                s_reject++;
            end
        end
        if (sync_valid_o || exp_sync) checkValue("sync_valid", 32'(sync_valid_o), 32'(exp_sync));
        if (sweep_valid_o || exp_sweep) checkValue("sweep_valid", 32'(sweep_valid_o), 32'(exp_sweep));
        if (exp_sync) begin
            checkValue("strobe.sync_skip", 32'(sync_skip_o), 32'(h_skip));
            checkValue("strobe.sync_data", 32'(sync_data_o), 32'(h_data));
            checkValue("strobe.sync_axis", 32'(sync_axis_o), 32'(h_axis));
            checkValue("strobe.sync_station", 32'(sync_station_o), 32'(h_station));
        end
        if (exp_sweep) begin
            checkValue("strobe.sweep_time", 32'(sweep_time_o), 32'(h_sw_time));
            checkValue("strobe.sweep_width", 32'(sweep_width_o), 32'(h_sw_width));
            checkValue("strobe.sweep_axis", 32'(sweep_axis_o), 32'(h_sw_axis));
        end
    endtask

    task automatic idle(input longint n);
        for (longint i = 0; i < n; i++) tick();
    endtask

    // Classify a finished pulse from its raw rise/fall cycles and queue the result.
    task automatic modelPulse(input longint rise_c, input longint fall_c, input int unsigned w);
        pulse_event_t ev;
        int unsigned code;
        ev.due = fall_c + 3;
        ev.kind = EV_REJECT;
        ev.skip = 0; ev.data = 0; ev.axis = 0; ev.station = 0;
        ev.t_val = 0; ev.w_val = 16'(w);
        if (w < MIN_PULSE) begin
            ev.kind = EV_REJECT;
        end else if (w <= SWEEP_MAX) begin
            if (have_ref && (fall_c - ref_rise) <= T_MAX) begin
                ev.kind = EV_SWEEP;
                ev.t_val = 20'(rise_c - ref_rise);
                ev.axis = ref_axis;
                ev.station = ref_station;
            end
        end else if (w >= SYNC_MIN && w < SYNC_MIN + 8 * SYNC_STEP) begin
            code = (w - SYNC_MIN) / SYNC_STEP;
            ev.kind = EV_SYNC;
            ev.skip = code[2];
            ev.data = code[1];
            ev.axis = code[0];
            ev.station = have_prev && ((rise_c - prev_sync_rise) < PAIR_WINDOW);
            have_prev = 1;
            prev_sync_rise = rise_c;
            if (!ev.skip) begin
                have_ref = 1;
                ref_rise = rise_c;
                ref_axis = ev.axis;
                ref_station = ev.station;
            end
        end
        exp_q.push_back(ev);
    endtask

    // Light for high_w cycles, then dark for low_w cycles.
    task automatic applyStimulus(input int unsigned high_w, input longint low_w);
        longint rise_c, fall_c;
        rise_c = 0;
        for (int unsigned i = 0; i < high_w; i++) begin
            tick();
            if (i == 0) rise_c = cyc;
            sensor_i = 1'b1;
        end
        tick();
        fall_c = cyc;
        sensor_i = 1'b0;
        modelPulse(rise_c, fall_c, high_w);
        for (longint i = 1; i < low_w; i++) tick();
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] e_sync, e_sweep, e_reject;
`ifdef DARKROOM_PULSE_STATS_EN
        e_sync = s_sync; e_sweep = s_sweep; e_reject = s_reject;
`else
        e_sync = 0; e_sweep = 0; e_reject = 0;
`endif
        checkValue({tag, ".sync_valid"}, 32'(sync_valid_o), 32'(0));
        checkValue({tag, ".sweep_valid"}, 32'(sweep_valid_o), 32'(0));
        checkValue({tag, ".sync_skip"}, 32'(sync_skip_o), 32'(h_skip));
        checkValue({tag, ".sync_data"}, 32'(sync_data_o), 32'(h_data));
        checkValue({tag, ".sync_axis"}, 32'(sync_axis_o), 32'(h_axis));
        checkValue({tag, ".sync_station"}, 32'(sync_station_o), 32'(h_station));
        checkValue({tag, ".sweep_axis"}, 32'(sweep_axis_o), 32'(h_sw_axis));
        checkValue({tag, ".sweep_station"}, 32'(sweep_station_o), 32'(h_sw_station));
        checkValue({tag, ".sweep_time"}, 32'(sweep_time_o), 32'(h_sw_time));
        checkValue({tag, ".sweep_width"}, 32'(sweep_width_o), 32'(h_sw_width));
        checkValue({tag, ".stat_sync"}, 32'(stat_sync_cnt_o), 32'(e_sync));
        checkValue({tag, ".stat_sweep"}, 32'(stat_sweep_cnt_o), 32'(e_sweep));
        checkValue({tag, ".stat_reject"}, 32'(stat_reject_cnt_o), 32'(e_reject));
    endtask

    initial begin
        int unsigned w;
        longint gap;
        sensor_i = 1'b0;
        reset_n = 1'b0;
        resetModel();
        idle(5);
        checkOutput("reset_state");
        tick();
        reset_n = 1'b1;
        idle(20);

        $display("[TB] sweep with no prior sync");
        applyStimulus(300, 50);
        checkOutput("sweep_no_sync");
        idle(31000);

        $display("[TB] code-1 sync");
        applyStimulus(3646, 100);
        checkOutput("sync_code1");

        $display("[TB] sync pair with skip on the second");
        applyStimulus(3125, 400);
        applyStimulus(5209, 100);
        checkOutput("sync_skip_pair");
        applyStimulus(300, 100);
        checkOutput("sweep_ref_kept");

        $display("[TB] sweep 100000 cycles after sync");
        applyStimulus(3125, 100000 - 3125);
        applyStimulus(300, 100);
        checkOutput("sweep_100k");

        $display("[TB] glitch and gap-band pulse");
        applyStimulus(10, 100);
        applyStimulus(2500, 200);
        checkOutput("rejects");

        $display("[TB] new rise during emit cycle");
        applyStimulus(3646, 1);
        applyStimulus(500, 100);
        checkOutput("emit_rise");

        $display("[TB] stale reference after t_ref saturation");
        applyStimulus(3125, 1048576 + 100);
        applyStimulus(300, 100);
        checkOutput("stale_ref");

        $display("[TB] random pulse train");
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 4))
                0:       w = $urandom_range(1, MIN_PULSE - 1);
                1, 2:    w = $urandom_range(MIN_PULSE, SWEEP_MAX);
                3:       w = SYNC_MIN + $urandom_range(0, 7) * SYNC_STEP + $urandom_range(0, SYNC_STEP - 1);
                default: w = ($urandom_range(0, 1) == 1) ? $urandom_range(SWEEP_MAX + 1, SYNC_MIN - 1)
                                                          : $urandom_range(SYNC_MIN + 8 * SYNC_STEP, SYNC_MIN + 8 * SYNC_STEP + 500);
            endcase
            gap = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(1, 3)) : longint'($urandom_range(4, 3000));
            applyStimulus(w, gap);
        end
        idle(20);
        checkOutput("random_end");

        $display("[TB] reset mid-pulse");
        tick();
        sensor_i = 1'b1;
        idle(50);
        tick();
        reset_n = 1'b0;
        resetModel();
        idle(5);
        checkOutput("reset_mid_pulse");
        tick();
        reset_n = 1'b1;
        idle(3000);
        tick();
        sensor_i = 1'b0;
        idle(200);
        checkOutput("partial_after_reset");
        idle(31000);
        applyStimulus(3646, 100);
        checkOutput("sync_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lighthouse_pulse_decoder.md
Name: lighthouse_pulse_decoder

Overview:
Per-sensor front end for the darkroom tracking system. Sits between one photodiode envelope input and the darkroom/OOTX consumers. Measures each light pulse, classifies it as sync (decoding skip/data/axis bits and base-station slot) or sweep, and timestamps sweeps against the last non-skipped sync. One instance per sensor line, 12 instances per design.

Parameters:
ACTIVE_HIGH, 1, sensor polarity (1: light = high)
MIN_PULSE, 25, widths below this are glitches (0.5 us @ 50 MHz)
SWEEP_MAX, 2000, max sweep width in cycles (40 us)
SYNC_MIN, 2865, lower edge of sync code 0 (62.5 us - half step)
SYNC_STEP, 521, cycles per sync code step (10.42 us)
PAIR_WINDOW, 30000, sync rise-to-rise gap below which a sync is station 1 (600 us)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
sensor_i  in  1  raw asynchronous envelope input
sync_valid_o  out  1  one-cycle strobe, sync pulse classified
sync_skip_o  out  1  skip bit (code[2])
sync_data_o  out  1  OOTX data bit (code[1])
sync_axis_o  out  1  axis bit (code[0])
sync_station_o  out  1  0 = first sync of pair, 1 = second
sweep_valid_o  out  1  one-cycle strobe, sweep classified
sweep_axis_o  out  1  axis of reference sync
sweep_station_o  out  1  station of reference sync
sweep_time_o  out  20  cycles from reference sync rise to sweep rise
sweep_width_o  out  16  sweep pulse width in cycles
stat_sync_cnt_o, stat_sweep_cnt_o, stat_reject_cnt_o  out  16 each  statistics (see Optional Feature)

Behaviour:
- Reset: all outputs 0, counters 0, sync_seen=0, state WAIT_LOW.
- Input: 2-flop synchronizer, polarity-normalised, edge detect. Same 2-cycle latency on rise and fall, so widths are exact.
- width counter: 16 bit, counts synchronized high cycles, saturates at 0xFFFF.
- t_ref: 20 bit, increments every cycle, saturates at 0xFFFFF. Saturation clears sync_seen.
- t_pair: 16 bit, cycles since last sync rise, saturating.
- WAIT_LOW: wait for level low, then IDLE. Entered at reset, so no partial pulse is measured after reset release mid-pulse.
- IDLE: on rise, width=1, capture t_ref into rise_t, then HIGH.
- HIGH: on fall, go to EMIT. All outputs register in EMIT, 1 cycle after the synchronized fall.
- EMIT (one cycle): classify width w.
  - w < MIN_PULSE: reject.
  - w <= SWEEP_MAX: sweep if sync_seen, else reject. Sweep outputs: sweep_valid_o=1, sweep_time_o=rise_t, sweep_width_o=w.
  - SYNC_MIN <= w < SYNC_MIN+8*SYNC_STEP: sync.
    - code = floor((w-SYNC_MIN)/SYNC_STEP), computed by a compare chain (no divider).
    - station = 1 if t_pair(at rise) < PAIR_WINDOW, else 0. t_pair restarts at rise.
    - If skip=0: t_ref <= w+1, latch axis and station, sync_seen=1.
  - Otherwise (gap band, too long, or saturated): reject.
  - Next state: HIGH if level already high (a new rise this cycle, width=1), else IDLE.
- Strobes are never asserted together. Payload outputs hold their value until the next strobe of the same kind.

Optional Feature:
DARKROOM_PULSE_STATS_EN:
- Defined: three 16-bit wrapping counters increment on sync_valid_o, sweep_valid_o, and reject.
- Undefined: stat ports tied to 0 and no counter logic is generated.

Decomposition:
- darkroom_pkg: state enum (WAIT_LOW, IDLE, HIGH, EMIT), pulse class enum (GLITCH, SWEEP, SYNC, REJECT), width constants T_WIDTH=20 and W_WIDTH=16, sync code bit indices.
- Sub-module sensor_input_sync: 2-flop synchronizer plus polarity normalisation plus rise/fall strobes.

Test Plan:
1. High for 3646 cycles (code 1) -> sync_valid_o at fall+1 with skip=0, data=0, axis=1, station=0.
2. Sync 3125 cycles, 400 cycles low, sync 5209 (code 4) -> second strobe shows skip=1, station=1. Reference is still the first sync (t_ref not reloaded).
3. Sync 3125 cycles, then a sweep rising 100000 cycles after the sync rise and lasting 300 -> sweep_valid_o with sweep_time_o=100000, sweep_width_o=300, axis=0.
4. 10-cycle glitch, then a 2500-cycle pulse -> no strobes; reject count 2 with stats enabled.
5. Sweep with no prior sync -> no strobe. Run 2^20 cycles after a sync, then a sweep -> no strobe (sync_seen cleared).
6. Assert reset_n low mid-pulse and release while input is high -> no strobe until a full low-high-low pulse completes; all outputs 0 after reset.
